// File: rtl/muladd_dot_seq.sv
// Sequencer driving one MULADD DSP BEL as an unsigned dot-product engine:
// clear accumulator, stream operand pairs, capture the final 20-bit sum.
module muladd_dot_seq #(
    parameter int unsigned LEN_W = 8
) (
    input  logic              user_clk_i,
    input  logic              clr_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [7:0]        op_a_i,
    input  logic [7:0]        op_b_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [19:0]       res_data_o,
    output logic [7:0]        mac_a_o,
    output logic [7:0]        mac_b_o,
    output logic [19:0]       mac_c_o,
    output logic              mac_clr_o,
    output logic [5:0]        mac_cfg_o,
    input  logic [19:0]       mac_q_i
);

    localparam int unsigned OP_W  = 8;
    localparam int unsigned ACC_W = 20;
    localparam int unsigned CFG_W = 6;

    // Unregistered A/B/C, accumulator feeds adder, no sign extension, Q = accumulator.
    localparam logic [CFG_W-1:0] MAC_CFG = 6'b101000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e             state_q;
    logic [LEN_W-1:0]   remaining_q;
    logic [ACC_W-1:0]   res_data_q;
    logic               busy_q;
    logic               res_valid_q;

    logic               in_run;
    logic               beat;

    // A beat is only acknowledged outside reset, so an aborted job never consumes a pair.
    always_comb begin
        in_run = (state_q == ST_RUN);
        beat   = in_run && op_valid_i && !clr_i;
    end

    // Operands reach the BEL only on an accepted beat; otherwise zeros keep the sum frozen.
    always_comb begin
        op_ready_o = in_run && !clr_i;
        mac_a_o    = beat ? op_a_i : OP_W'(0);
        mac_b_o    = beat ? op_b_i : OP_W'(0);
        mac_clr_o  = clr_i || (state_q == ST_CLEAR);
        mac_c_o    = ACC_W'(0);
        mac_cfg_o  = MAC_CFG;
    end

    always_comb begin
        busy_o      = busy_q;
        res_valid_o = res_valid_q;
        res_data_o  = res_data_q;
    end

    // Job sequencing FSM with registered status flags and result.
    always_ff @(posedge user_clk_i) begin
        if (clr_i) begin
            state_q     <= ST_IDLE;
            remaining_q <= LEN_W'(0);
            res_data_q  <= ACC_W'(0);
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        remaining_q <= len_i;
                        busy_q      <= 1'b1;
                        state_q     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (remaining_q == LEN_W'(0)) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (beat) begin
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Last product landed in the accumulator on the previous edge.
                    res_data_q  <= mac_q_i;
                    res_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
